// File: rtl/led_status_ctrl_pkg.sv
// Shared types and helpers for the status-LED controller.
package led_status_pkg;

  typedef enum logic [1:0] {
    ACT_IDLE_S = 2'b00,
    ACT_ON     = 2'b01,
    ACT_GAP    = 2'b10
  } act_state_t;

  // Width able to hold values 0..value-1, never narrower than one bit.
  function automatic int cnt_width(input int value);
    return $clog2((value < 2) ? 2 : value);
  endfunction

endpackage

// File: rtl/led_status_ctrl_if.sv
// Bundle of activity/trigger inputs and LED outputs of the status controller.
interface led_status_ctrl_if #(
  parameter int NUM_ACT = 2
);
  logic [NUM_ACT-1:0] act_in;
  logic               trig_in;
  logic               quiet_en;
  logic               led_heartbeat;
  logic [NUM_ACT-1:0] led_act;
  logic               led_trig;

  modport master (
    output act_in, trig_in, quiet_en,
    input  led_heartbeat, led_act, led_trig
  );

  modport slave (
    input  act_in, trig_in, quiet_en,
    output led_heartbeat, led_act, led_trig
  );
endinterface

// File: rtl/led_status_ctrl_act_stretcher.sv
// One activity channel: synchroniser, transition detect and ON/GAP blink stretcher.
module act_stretcher
  import led_status_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter logic ACT_IDLE       = 1'b1,
  parameter int   STRETCH_CYCLES = 4096
) (
  input  logic ext_clock,
  input  logic reset,
  input  logic act_in,
  input  logic freeze,
  output logic led_act
);

  localparam int            CW       = cnt_width(STRETCH_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  act_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   act_event;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], act_in};
    prev_d    = sync_q[SYNC_STAGES-1];
    act_event = sync_q[SYNC_STAGES-1] ^ prev_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    // Frozen channels only remember that something happened.
    if (freeze) begin
      if (act_event) pending_d = 1'b1;
    end else begin
      case (state_q)
        ACT_IDLE_S: begin
          if (act_event | pending_q) begin
            state_d   = ACT_ON;
            cnt_d     = CNT_LOAD;
            pending_d = 1'b0;
          end
        end
        ACT_ON: begin
          if (act_event) pending_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = ACT_GAP;
            cnt_d   = CNT_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ACT_GAP: begin
          if (cnt_q == '0) begin
            if (act_event | pending_q) begin
              state_d   = ACT_ON;
              cnt_d     = CNT_LOAD;
              pending_d = 1'b0;
            end else begin
              state_d = ACT_IDLE_S;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (act_event) pending_d = 1'b1;
          end
        end
        default: state_d = ACT_IDLE_S;
      endcase
    end
  end

  always_ff @(posedge ext_clock) begin
    if (reset) begin
      sync_q    <= {SYNC_STAGES{ACT_IDLE}};
      prev_q    <= ACT_IDLE;
      state_q   <= ACT_IDLE_S;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign led_act = (state_q == ACT_ON);

endmodule

// File: rtl/led_status_ctrl.sv
// Status-LED controller: heartbeat, stretched activity LEDs and held trigger LED,
// with a quiet mode that freezes switching logic during a capture.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int               HB_WIDTH         = 23,
  parameter int               NUM_ACT          = 2,
  parameter int               SYNC_STAGES      = 2,
  parameter logic [NUM_ACT-1:0] ACT_IDLE       = {NUM_ACT{1'b1}},
  parameter int               STRETCH_CYCLES   = 4096,
  parameter int               TRIG_HOLD_CYCLES = 4096
) (
  input logic              ext_clock,
  input logic              reset,
  led_status_ctrl_if.slave bus
);

  localparam int            HW        = cnt_width(TRIG_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(TRIG_HOLD_CYCLES);

  logic                freeze;
  logic [HB_WIDTH-1:0] hb_q, hb_d;
  logic                trig_q, trig_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [NUM_ACT-1:0]  led_act;

  assign freeze = bus.quiet_en & bus.trig_in;

  // The hold counter keeps running through a freeze so led_trig stays honest.
  always_comb begin
    hb_d   = freeze ? hb_q : hb_q + 1'b1;
    trig_d = bus.trig_in;
    hold_d = hold_q;
    if (trig_q && !bus.trig_in) begin
      hold_d = HOLD_LOAD;
    end else if (trig_q) begin
      hold_d = '0;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_ff @(posedge ext_clock) begin
    if (reset) begin
      hb_q   <= '0;
      trig_q <= 1'b0;
      hold_q <= '0;
    end else begin
      hb_q   <= hb_d;
      trig_q <= trig_d;
      hold_q <= hold_d;
    end
  end

  for (genvar i = 0; i < NUM_ACT; i++) begin : g_act
    act_stretcher #(
      .SYNC_STAGES   (SYNC_STAGES),
      .ACT_IDLE      (ACT_IDLE[i]),
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_act (
      .ext_clock(ext_clock),
      .reset    (reset),
      .act_in   (bus.act_in[i]),
      .freeze   (freeze),
      .led_act  (led_act[i])
    );
  end

  assign bus.led_heartbeat = hb_q[HB_WIDTH-1];
  assign bus.led_act       = led_act;
  assign bus.led_trig      = trig_q | (hold_q != '0);

endmodule

// File: doc/led_status_ctrl.md
# led_status_ctrl

Parametrised status-LED controller for the CW305 DesignStart top level. It replaces the fixed 23-bit heartbeat counter and the raw XOR/trigger LED assignments. It drives a heartbeat LED, NUM_ACT pulse-stretched activity LEDs (UART RX/TX and similar) and a trigger LED with minimum on-time. A quiet mode freezes all switching logic while a capture trigger is active.

## Interface
- HB_WIDTH, 23: heartbeat counter width; led_heartbeat = counter MSB.
- NUM_ACT, 2: number of activity channels.
- SYNC_STAGES, 2: synchroniser depth per activity input (min 2).
- ACT_IDLE, {NUM_ACT{1'b1}}: idle level of each act_in bit; reset value of its synchroniser.
- STRETCH_CYCLES, 4096: ON and GAP length per activity blink (min 1).
- TRIG_HOLD_CYCLES, 4096: extra led_trig on-time after trigger falls (min 0).
- ext_clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- act_in  in  NUM_ACT  asynchronous activity levels; any transition is an event.
- trig_in  in  1  capture trigger, synchronous to ext_clock.
- quiet_en  in  1  enables freeze while trig_in=1.
- led_heartbeat  out  1  heartbeat.
- led_act  out  NUM_ACT  stretched activity indicators.
- led_trig  out  1  trigger indicator.

## Operation
- Reset: all outputs 0. Heartbeat, stretch and hold counters 0. FSMs in IDLE. pending = 0. Synchronisers = ACT_IDLE. Reset overrides freeze.
- freeze = quiet_en & trig_in.
- Heartbeat: the counter increments by 1 per cycle unless frozen. It wraps modulo 2^HB_WIDTH.
- Activity channel: act_in[i] passes through SYNC_STAGES flops. event = sync_out XOR prev_sync, where prev_sync is a registered copy.
- Per-channel FSM (Moore; led_act[i] = state==ON):
  - IDLE: if (event | pending) and not frozen, go to ON, load cnt = STRETCH_CYCLES-1, clear pending.
  - ON: if cnt==0, go to GAP and load cnt = STRETCH_CYCLES-1; otherwise decrement cnt.
  - GAP: if cnt==0, go to ON if (event | pending), clearing pending; otherwise go to IDLE. If cnt!=0, decrement cnt.
  - An event in ON or GAP that does not cause a transition that cycle sets pending.
  - While frozen, state and cnt hold. Events still set pending. prev_sync keeps tracking.
- Trigger: trig_q is trig_in registered.
  - When trig_q=1 and trig_in=0: hold_cnt loads TRIG_HOLD_CYCLES.
  - Otherwise, if hold_cnt!=0 and trig_q=0: hold_cnt decrements.
  - trig_q=1 clears hold_cnt.
  - led_trig = trig_q | (hold_cnt!=0). The hold counter is never frozen.
- Counter widths: $clog2 of max(value,2), so all counters are ≥1 bit and no truncation occurs.

## Timing
- act_in change set up before edge k: led_act rises after edge k+SYNC_STAGES, if not frozen and FSM was IDLE.
- ON lasts exactly STRETCH_CYCLES cycles. GAP lasts exactly STRETCH_CYCLES cycles. Continuous traffic gives a 50 % blink with period 2·STRETCH_CYCLES.
- Event on the same cycle ON expires: pending is set and the FSM goes to GAP. Event on the cycle GAP expires: the FSM goes directly to ON.
- led_trig rises 1 cycle after trig_in. It stays high for the trig_in duration plus TRIG_HOLD_CYCLES. Retrigger during hold extends it seamlessly.
- Freeze starts on the cycle trig_in=1 is sampled with quiet_en=1. Counting resumes on the first cycle trig_in=0.
- Reset mid-operation: outputs are 0 after the reset edge. pending is discarded.

## Structure
- Package led_status_pkg:
  - act_state_t enum: ACT_IDLE_S=2'b00, ACT_ON=2'b01, ACT_GAP=2'b10.
  - Function for safe counter width.
- Sub-module act_stretcher: synchroniser, edge detect, FSM and counter for one channel. It is instantiated NUM_ACT times via generate.
- Heartbeat and trigger-hold logic stay in led_status_ctrl.

## Test plan
Bench parameters: HB_WIDTH=4, NUM_ACT=2, SYNC_STAGES=2, STRETCH_CYCLES=4, TRIG_HOLD_CYCLES=3, ACT_IDLE=2'b11.
- Reset 3 cycles, inputs idle, then run: all outputs 0 during reset. led_heartbeat rises after 8 cycles and falls after 16. led_act stays 0 (no spurious event from ACT_IDLE).
- act_in[0] 1→0 before edge k: led_act[0]=1 after edges k+2 through k+5, then 0. led_act[1] stays 0.
- act_in[1] toggled every 2 cycles for 40 cycles: led_act[1] alternates 4 on / 4 off. One more ON period follows the last toggle (pending), then IDLE.
- trig_in high 5 cycles, quiet_en=0: led_trig high for 8 consecutive cycles starting 1 cycle after trig_in rises. The heartbeat keeps counting.
- quiet_en=1, trig_in high 10 cycles with heartbeat count=5, act_in[0] toggles mid-freeze: the count holds 5 and led_act[0] stays 0 during freeze. led_act[0] rises on the first unfrozen cycle, lasting 4 cycles.
- reset asserted while led_act[0]=1 (ON) with pending=1 and hold_cnt=2: all outputs 0 on the next cycle. After release there is no blink without a new event.
